// File: rtl/ex_mem.sv
// ex_mem: EX->MEM pipeline register with valid/ready handshake and a one-entry skid buffer.
// Optional stall counter output is built when EX_MEM_STALL_CNT_EN is defined.
module ex_mem #(
  parameter int XLEN = 64,
  parameter int WW   = 8
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic            flush,
  input  logic            ex_exmem_valid,
  output logic            ex_exmem_ready,
  input  logic [XLEN-1:0] ex_exmem_alu_result,
  input  logic            ex_exmem_is_write_dmem,
  input  logic [1:0]      ex_exmem_wb_select,
  input  logic [WW-1:0]   ex_exmem_write_width,
  input  logic [XLEN-1:0] ex_exmem_dmem_write_data,
  input  logic            ex_exmem_pc_sel,
  output logic            exmem_mem_valid,
  input  logic            exmem_mem_ready,
  output logic [XLEN-1:0] exmem_mem_alu_result,
  output logic            exmem_mem_is_write_dmem,
  output logic [1:0]      exmem_mem_wb_select,
  output logic [WW-1:0]   exmem_mem_write_width,
  output logic [XLEN-1:0] exmem_mem_dmem_write_data,
`ifdef EX_MEM_STALL_CNT_EN
  output logic            exmem_mem_pc_sel,
  output logic [31:0]     exmem_stall_cnt
`else
  output logic            exmem_mem_pc_sel
`endif
);
  localparam int P = 2 * XLEN + WW + 4;
  logic [P-1:0] r_main, r_skid;
  logic         r_main_valid, r_skid_valid;
  logic [P-1:0] w_in;
  logic         w_accept, w_drain, w_adv;
  assign w_in = {ex_exmem_alu_result, ex_exmem_is_write_dmem, ex_exmem_wb_select,
                 ex_exmem_write_width, ex_exmem_dmem_write_data, ex_exmem_pc_sel};
  // ready depends only on state, reset and flush so MEM stalls never feed back combinationally
  assign ex_exmem_ready = ~r_skid_valid & ~sys_rst & ~flush;
  assign w_accept       = ex_exmem_valid & ex_exmem_ready;
  assign w_drain        = r_main_valid & exmem_mem_ready;
  assign w_adv          = ~r_main_valid | w_drain;
  assign exmem_mem_valid = r_main_valid;
  assign {exmem_mem_alu_result, exmem_mem_is_write_dmem, exmem_mem_wb_select,
          exmem_mem_write_width, exmem_mem_dmem_write_data, exmem_mem_pc_sel} = r_main;
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_main       <= '0;
      r_skid       <= '0;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_adv && r_skid_valid) begin
      r_main       <= r_skid;
      r_main_valid <= 1'b1;
      r_skid_valid <= w_accept;
      if (w_accept) r_skid <= w_in;
    end else if (w_adv) begin
      r_main       <= w_in;
      r_main_valid <= w_accept;
    end else if (w_accept) begin
      r_skid       <= w_in;
      r_skid_valid <= 1'b1;
    end
  end
`ifdef EX_MEM_STALL_CNT_EN
  logic [31:0] r_stall_cnt;
  assign exmem_stall_cnt = r_stall_cnt;
  always_ff @(posedge sys_clk) begin
    if (sys_rst) r_stall_cnt <= '0;
    else if (!flush && r_main_valid && !exmem_mem_ready) r_stall_cnt <= r_stall_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_ex_mem.sv
// tb_ex_mem: randomized check of ex_mem against a two-deep in-order queue model.
module tb_ex_mem;
  typedef struct {
    logic [63:0] alu;
    logic        wr;
    logic [1:0]  wb;
    logic [7:0]  ww;
    logic [63:0] wd;
    logic        pc;
  } ent_t;
  logic        sys_clk = 1'b0;
  logic        sys_rst, flush, ex_exmem_valid, ex_exmem_ready, exmem_mem_valid, exmem_mem_ready;
  logic [63:0] exmem_mem_alu_result, exmem_mem_dmem_write_data;
  logic        exmem_mem_is_write_dmem, exmem_mem_pc_sel;
  logic [1:0]  exmem_mem_wb_select;
  logic [7:0]  exmem_mem_write_width;
  ent_t        in_e;
  ent_t        q[$];
  int          n_chk = 0, n_fail = 0;
  bit          was_rst = 1'b0;
`ifdef EX_MEM_STALL_CNT_EN
  logic [31:0] exmem_stall_cnt;
  logic [31:0] cnt_exp = '0;
`endif
  always #5 sys_clk = ~sys_clk;
  ex_mem #(.XLEN(64), .WW(8)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .flush(flush),
    .ex_exmem_valid(ex_exmem_valid), .ex_exmem_ready(ex_exmem_ready),
    .ex_exmem_alu_result(in_e.alu), .ex_exmem_is_write_dmem(in_e.wr),
    .ex_exmem_wb_select(in_e.wb), .ex_exmem_write_width(in_e.ww),
    .ex_exmem_dmem_write_data(in_e.wd), .ex_exmem_pc_sel(in_e.pc),
    .exmem_mem_valid(exmem_mem_valid), .exmem_mem_ready(exmem_mem_ready),
    .exmem_mem_alu_result(exmem_mem_alu_result), .exmem_mem_is_write_dmem(exmem_mem_is_write_dmem),
    .exmem_mem_wb_select(exmem_mem_wb_select), .exmem_mem_write_width(exmem_mem_write_width),
    .exmem_mem_dmem_write_data(exmem_mem_dmem_write_data),
`ifdef EX_MEM_STALL_CNT_EN
    .exmem_mem_pc_sel(exmem_mem_pc_sel), .exmem_stall_cnt(exmem_stall_cnt)
`else
    .exmem_mem_pc_sel(exmem_mem_pc_sel)
`endif
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic v, input logic mr, input logic fl, input logic rs, input logic [63:0] alu);
    ex_exmem_valid  = v;
    exmem_mem_ready = mr;
    flush           = fl;
    sys_rst         = rs;
    in_e.alu        = alu;
    in_e.wr         = 1'($urandom);
    in_e.wb         = 2'($urandom);
    in_e.ww         = 8'($urandom);
    in_e.wd         = {$urandom, $urandom};
    in_e.pc         = 1'($urandom);
  endtask
  task automatic cycle;
    bit   acc, drn, rs, fl, rdy;
    ent_t e;
    #1;
    rdy = (q.size() < 2) && !sys_rst && !flush;
    chk("ready", ex_exmem_ready, rdy);
    acc = ex_exmem_valid && rdy;
    drn = (q.size() > 0) && exmem_mem_ready;
    rs  = sys_rst;
    fl  = flush;
    e   = in_e;
    @(posedge sys_clk);
`ifdef EX_MEM_STALL_CNT_EN
    if (rs) cnt_exp = '0;
    else if (!fl && q.size() > 0 && !drn) cnt_exp = cnt_exp + 32'd1;
`endif
    was_rst = rs;
    if (rs || fl) q.delete();
    else begin
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    @(negedge sys_clk);
    chk("valid", exmem_mem_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk("alu", exmem_mem_alu_result, q[0].alu);
      chk("is_write", exmem_mem_is_write_dmem, q[0].wr);
      chk("wb_sel", exmem_mem_wb_select, q[0].wb);
      chk("wwidth", exmem_mem_write_width, q[0].ww);
      chk("wdata", exmem_mem_dmem_write_data, q[0].wd);
      chk("pc_sel", exmem_mem_pc_sel, q[0].pc);
    end else if (was_rst) begin
      chk("rst_payload", {exmem_mem_alu_result ^ exmem_mem_dmem_write_data, exmem_mem_is_write_dmem,
          exmem_mem_wb_select, exmem_mem_write_width, exmem_mem_pc_sel} == '0, 1'b1);
      chk("rst_alu", exmem_mem_alu_result, 64'h0);
    end
`ifdef EX_MEM_STALL_CNT_EN
    chk("stall_cnt", exmem_stall_cnt, cnt_exp);
`endif
  endtask
  initial begin
    drive(0, 1, 0, 1, 64'h0);
    @(negedge sys_clk);
    repeat (2) cycle();
    drive(1, 1, 0, 0, 64'h1234);
    cycle();
    chk("t1_alu", exmem_mem_alu_result, 64'h1234);
    chk("t1_valid", exmem_mem_valid, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      drive(1, 1, 0, 0, 64'(i));
      cycle();
      chk("t1_seq", exmem_mem_alu_result, 64'(i));
    end
    drive(0, 1, 0, 0, 64'h0);
    cycle();
    drive(1, 0, 0, 0, 64'hA);
    cycle();
    drive(1, 0, 0, 0, 64'hB);
    cycle();
    chk("t2_a_held", exmem_mem_alu_result, 64'hA);
    chk("t2_full", ex_exmem_ready, 1'b0);
    drive(0, 1, 0, 0, 64'h0);
    cycle();
    chk("t2_b", exmem_mem_alu_result, 64'hB);
    chk("t2_ready_back", ex_exmem_ready, 1'b1);
    cycle();
    drive(1, 0, 0, 0, 64'h5);
    cycle();
    cycle();
    drive(1, 0, 1, 0, 64'hC);
    cycle();
    chk("t3_flushed", exmem_mem_valid, 1'b0);
    drive(0, 0, 0, 0, 64'h0);
    cycle();
    drive(1, 0, 0, 0, 64'h77);
    in_e.wr = 1'b1;
    in_e.ww = 8'h0F;
    in_e.wd = 64'hDEADBEEF;
    in_e.wb = 2'b10;
    cycle();
    ex_exmem_valid = 1'b0;
    repeat (5) cycle();
    chk("t4_wdata", exmem_mem_dmem_write_data, 64'hDEADBEEF);
    chk("t4_ww", exmem_mem_write_width, 64'h0F);
    drive(1, 0, 0, 0, 64'h88);
    cycle();
    drive(1, 0, 0, 1, 64'h99);
    cycle();
    chk("t5_rst_valid", exmem_mem_valid, 1'b0);
    drive(0, 1, 0, 0, 64'h0);
    cycle();
    for (int i = 0; i < 500; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
            $urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0, {$urandom, $urandom});
      cycle();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
